// File: rtl/alu_pkg.sv
// ALU types and helpers built on the shared global parameters.
// Provides word/id/opcode typedefs and the boolean-to-word helper used by the
// compare operations.
`include "global_params.v"

package alu_pkg;

    typedef logic [`XLEN-1:0]           word_t;
    typedef logic [`ROB_SIZE_WIDTH-1:0] rob_id_t;
    typedef logic [`ALU_OP_WIDTH-1:0]   alu_op_t;

    // Shift amount is always the low five bits of operand 2.
    localparam int unsigned SHAMT_W = 5;

    // Compare results are architecturally 1 or 0 in a full word.
    function automatic word_t bool_to_word(input logic cond);
        word_t w;
        w = {`XLEN{1'b0}};
        if (cond) begin
            w[0] = 1'b1;
        end else begin
            w[0] = 1'b0;
        end
        return w;
    endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath.
// Ports:
//   op  - ALU opcode (`ALU_* encodings)
//   a   - operand 1
//   b   - operand 2; shifts use only b[4:0]
//   res - result; unknown opcodes give zero
`include "global_params.v"

module alu_core
    import alu_pkg::*;
(
    input  logic [`ALU_OP_WIDTH-1:0] op,
    input  logic [`XLEN-1:0]         a,
    input  logic [`XLEN-1:0]         b,
    output logic [`XLEN-1:0]         res
);

    logic [SHAMT_W-1:0] shamt_s;
    word_t              res_s;

    assign shamt_s = b[SHAMT_W-1:0];
    assign res     = res_s;

    // Opcode decode and operation select.
    always_comb begin
        res_s = {`XLEN{1'b0}};
        case (op)
            `ALU_ADD:  res_s = a + b;
            `ALU_SUB:  res_s = a - b;
            `ALU_AND:  res_s = a & b;
            `ALU_OR:   res_s = a | b;
            `ALU_XOR:  res_s = a ^ b;
            `ALU_SHL:  res_s = a << shamt_s;
            `ALU_SHR:  res_s = a >> shamt_s;
            `ALU_SHRA: res_s = $unsigned($signed(a) >>> shamt_s);
            `ALU_EQ:   res_s = bool_to_word(a == b);
            `ALU_NEQ:  res_s = bool_to_word(a != b);
            `ALU_LT:   res_s = bool_to_word($signed(a) <  $signed(b));
            `ALU_LTU:  res_s = bool_to_word(a <  b);
            `ALU_GE:   res_s = bool_to_word($signed(a) >= $signed(b));
            `ALU_GEU:  res_s = bool_to_word(a >= b);
            default:   res_s = {`XLEN{1'b0}};
        endcase
    end

endmodule

// File: rtl/global_params.v
// Shared machine-wide parameters: data width, ROB id width, ALU opcode width
// and the ALU opcode encodings. Every block that needs these includes this
// header; nothing redefines them locally.
`ifndef GLOBAL_PARAMS_V
`define GLOBAL_PARAMS_V

`define XLEN            32
`define ROB_SIZE_WIDTH  4
`define ALU_OP_WIDTH    5

// Encoding 0 is deliberately unused so an uninitialised opcode yields zero.
`define ALU_ADD   5'd1
`define ALU_SUB   5'd2
`define ALU_AND   5'd3
`define ALU_OR    5'd4
`define ALU_XOR   5'd5
`define ALU_SHL   5'd6
`define ALU_SHR   5'd7
`define ALU_SHRA  5'd8
`define ALU_EQ    5'd9
`define ALU_NEQ   5'd10
`define ALU_LT    5'd11
`define ALU_LTU   5'd12
`define ALU_GE    5'd13
`define ALU_GEU   5'd14

`endif

// File: rtl/alu.sv
// ALU execution unit: one op per cycle from the reservation station, result
// broadcast on the common data bus exactly one cycle later.
// Ports:
//   clk, rst (async active-low), rdy (global enable), flush (ROB mispredict)
//   rs_ready/rs_op/rs_val1/rs_val2/rs_id - op issued by the reservation station
//   alu_ready/alu_res/alu_id             - registered CDB broadcast
`include "global_params.v"

module alu
    import alu_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rdy,
    input  logic                       flush,
    input  logic                       rs_ready,
    input  logic [`ALU_OP_WIDTH-1:0]   rs_op,
    input  logic [`XLEN-1:0]           rs_val1,
    input  logic [`XLEN-1:0]           rs_val2,
    input  logic [`ROB_SIZE_WIDTH-1:0] rs_id,
    output logic                       alu_ready,
    output logic [`XLEN-1:0]           alu_res,
    output logic [`ROB_SIZE_WIDTH-1:0] alu_id
);

    word_t   core_res_s;
    logic    valid_r;
    word_t   res_r;
    rob_id_t id_r;

    alu_core u_core (
        .op  (rs_op),
        .a   (rs_val1),
        .b   (rs_val2),
        .res (core_res_s)
    );

    // Output register: flush wins over issue; result/id only load on a real
    // issue so they keep the last broadcast value otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_r <= 1'b0;
            res_r   <= {`XLEN{1'b0}};
            id_r    <= {`ROB_SIZE_WIDTH{1'b0}};
        end else if (rdy) begin
            if (flush) begin
                valid_r <= 1'b0;
            end else if (rs_ready) begin
                valid_r <= 1'b1;
                res_r   <= core_res_s;
                id_r    <= rs_id;
            end else begin
                valid_r <= 1'b0;
            end
        end
    end

    assign alu_ready = valid_r;
    assign alu_res   = res_r;
    assign alu_id    = id_r;

endmodule

// File: tb/tb_alu.sv
// Directed testbench for alu with hand-computed expected values.
`include "global_params.v"

module tb_alu;

    logic                       clk;
    logic                       rst;
    logic                       rdy;
    logic                       flush;
    logic                       rs_ready;
    logic [`ALU_OP_WIDTH-1:0]   rs_op;
    logic [`XLEN-1:0]           rs_val1;
    logic [`XLEN-1:0]           rs_val2;
    logic [`ROB_SIZE_WIDTH-1:0] rs_id;
    logic                       alu_ready;
    logic [`XLEN-1:0]           alu_res;
    logic [`ROB_SIZE_WIDTH-1:0] alu_id;

    int n_cmp;
    int n_bad;

    alu dut (
        .clk       (clk),
        .rst       (rst),
        .rdy       (rdy),
        .flush     (flush),
        .rs_ready  (rs_ready),
        .rs_op     (rs_op),
        .rs_val1   (rs_val1),
        .rs_val2   (rs_val2),
        .rs_id     (rs_id),
        .alu_ready (alu_ready),
        .alu_res   (alu_res),
        .alu_id    (alu_id)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point for the whole bench.
    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (obs !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic rdy_e,
                           input logic [31:0] res_e, input logic [31:0] id_e);
        chk_val({tag, ".ready"}, {31'd0, alu_ready}, {31'd0, rdy_e});
        chk_val({tag, ".res"}, alu_res, res_e);
        chk_val({tag, ".id"}, {28'd0, alu_id}, id_e);
    endtask

    // Drive one cycle of inputs, clock it, and land 1 time unit after the edge.
    task automatic step(input logic rdy_v, input logic flush_v, input logic rsr_v,
                        input logic [`ALU_OP_WIDTH-1:0] op_v,
                        input logic [31:0] a_v, input logic [31:0] b_v,
                        input logic [3:0] id_v);
        rdy      = rdy_v;
        flush    = flush_v;
        rs_ready = rsr_v;
        rs_op    = op_v;
        rs_val1  = a_v;
        rs_val2  = b_v;
        rs_id    = id_v;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [`ALU_OP_WIDTH-1:0] op_v,
                         input logic [31:0] a_v, input logic [31:0] b_v,
                         input logic [3:0] id_v);
        step(1'b1, 1'b0, 1'b1, op_v, a_v, b_v, id_v);
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 4'd0);
    endtask

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        rst      = 1'b0;
        rdy      = 1'b1;
        flush    = 1'b0;
        rs_ready = 1'b1;
        rs_op    = `ALU_ADD;
        rs_val1  = 32'd1;
        rs_val2  = 32'd1;
        rs_id    = 4'd9;

        // Reset state, with an op presented that must be lost.
        #2;
        chk_out("reset0", 1'b0, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        chk_out("reset_edge", 1'b0, 32'h0, 32'h0);
        rst      = 1'b1;
        rs_ready = 1'b0;

        // Basic add, latency 1, then valid drops while data holds.
        issue(`ALU_ADD, 32'd7, 32'd5, 4'd3);
        chk_out("add", 1'b1, 32'd12, 32'd3);
        idle();
        chk_out("add_after", 1'b0, 32'd12, 32'd3);

        // Back-to-back, no bubble.
        issue(`ALU_SUB, 32'd0, 32'd1, 4'd1);
        chk_out("sub", 1'b1, 32'hFFFF_FFFF, 32'd1);
        issue(`ALU_SHRA, 32'h8000_0000, 32'h0000_0021, 4'd2);
        chk_out("shra", 1'b1, 32'hC000_0000, 32'd2);

        // Compares.
        issue(`ALU_LT, 32'hFFFF_FFFF, 32'd1, 4'd4);
        chk_val("lt", alu_res, 32'd1);
        issue(`ALU_LTU, 32'hFFFF_FFFF, 32'd1, 4'd5);
        chk_val("ltu", alu_res, 32'd0);
        issue(`ALU_GE, 32'd5, 32'd5, 4'd6);
        chk_val("ge", alu_res, 32'd1);
        issue(`ALU_NEQ, 32'd4, 32'd4, 4'd7);
        chk_val("neq", alu_res, 32'd0);
        issue(`ALU_EQ, 32'd4, 32'd4, 4'd8);
        chk_val("eq", alu_res, 32'd1);
        issue(`ALU_GEU, 32'd1, 32'hFFFF_FFFF, 4'd9);
        chk_val("geu", alu_res, 32'd0);
        issue(`ALU_GE, 32'hFFFF_FFFE, 32'd3, 4'd10);
        chk_val("ge_neg", alu_res, 32'd0);

        // Arithmetic wrap, logic ops and shifts using only b[4:0].
        issue(`ALU_ADD, 32'hFFFF_FFFF, 32'd2, 4'd11);
        chk_val("add_wrap", alu_res, 32'd1);
        issue(`ALU_AND, 32'hF0F0_1234, 32'h0FF0_FF00, 4'd12);
        chk_val("and", alu_res, 32'h00F0_1200);
        issue(`ALU_OR, 32'hF000_0001, 32'h0000_0F00, 4'd13);
        chk_val("or", alu_res, 32'hF000_0F01);
        issue(`ALU_XOR, 32'hAAAA_5555, 32'hFFFF_0000, 4'd14);
        chk_val("xor", alu_res, 32'h5555_5555);
        issue(`ALU_SHL, 32'd1, 32'h0000_003F, 4'd15);
        chk_val("shl", alu_res, 32'h8000_0000);
        issue(`ALU_SHR, 32'h8000_0000, 32'hFFFF_FFE4, 4'd0);
        chk_val("shr", alu_res, 32'h0800_0000);
        issue(`ALU_SHRA, 32'h4000_0000, 32'd30, 4'd1);
        chk_val("shra_pos", alu_res, 32'd1);

        // Unknown opcodes: zero result but still a completion.
        issue(5'd0, 32'd123, 32'd456, 4'd2);
        chk_out("op0", 1'b1, 32'd0, 32'd2);
        issue(5'd31, 32'd123, 32'd456, 4'd3);
        chk_out("op31", 1'b1, 32'd0, 32'd3);

        // Flush: existing result stays visible in the flush cycle,
        // the op issued alongside the flush is discarded.
        issue(`ALU_ADD, 32'd1, 32'd2, 4'd5);
        chk_out("pre_flush", 1'b1, 32'd3, 32'd5);
        rdy      = 1'b1;
        flush    = 1'b1;
        rs_ready = 1'b1;
        rs_op    = `ALU_ADD;
        rs_val1  = 32'd9;
        rs_val2  = 32'd9;
        rs_id    = 4'd6;
        #1;
        chk_out("flush_cycle", 1'b1, 32'd3, 32'd5);
        @(posedge clk);
        #1;
        chk_out("post_flush", 1'b0, 32'd3, 32'd5);

        // rdy low freezes everything, including a pending valid.
        issue(`ALU_ADD, 32'd10, 32'd20, 4'd7);
        chk_out("pre_hold", 1'b1, 32'd30, 32'd7);
        step(1'b0, 1'b0, 1'b1, `ALU_SUB, 32'd100, 32'd1, 4'd8);
        chk_out("hold1", 1'b1, 32'd30, 32'd7);
        step(1'b0, 1'b1, 1'b0, `ALU_ADD, 32'd5, 32'd5, 4'd9);
        chk_out("hold2", 1'b1, 32'd30, 32'd7);
        step(1'b0, 1'b0, 1'b0, `ALU_XOR, 32'd5, 32'd5, 4'd10);
        chk_out("hold3", 1'b1, 32'd30, 32'd7);

        // Async reset between edges, clears immediately.
        #2;
        rst = 1'b0;
        #1;
        chk_out("async_rst", 1'b0, 32'd0, 32'd0);

        // Ops presented during reset are lost.
        step(1'b1, 1'b0, 1'b1, `ALU_ADD, 32'd50, 32'd50, 4'd11);
        chk_out("rst_lost", 1'b0, 32'd0, 32'd0);
        rst = 1'b1;
        idle();
        chk_out("rst_release", 1'b0, 32'd0, 32'd0);
        issue(`ALU_SUB, 32'd10, 32'd3, 4'd12);
        chk_out("after_rst", 1'b1, 32'd7, 32'd12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
